// File: rtl/machine_timer_pkg.sv
// Shared constants for the machine timer: register word indices, control bits
// and the bus handshake state encoding.
package machine_timer_pkg;

  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_CONTROL     = 3'd4;
  localparam logic [2:0] REG_PRESCALE    = 3'd5;

  localparam int CTRL_COUNT_EN = 0;
  localparam int CTRL_IRQ_EN   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } bus_state_t;

endpackage

// File: rtl/timer_counter.sv
// 64-bit mtime counter advanced by a down-counting prescaler; bus word loads
// override the tick for the whole counter on the same edge.
module timer_counter #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [PRESCALE_WIDTH-1:0] i_reload,
  input  logic                      i_reload_load,
  input  logic [PRESCALE_WIDTH-1:0] i_reload_data,
  input  logic                      i_load_lo,
  input  logic                      i_load_hi,
  input  logic [31:0]               i_load_data,
  output logic [63:0]               o_mtime
);

  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [63:0]               mtime_q, mtime_d;
  logic                      tick;

  always_comb begin
    tick    = i_enable && (presc_q == '0);
    presc_d = presc_q;
    if (i_reload_load) begin
      presc_d = i_reload_data;
    end else if (i_enable) begin
      presc_d = tick ? i_reload : presc_q - 1'b1;
    end

    // A load of either word suppresses the tick so the other word stays put.
    mtime_d = mtime_q;
    if (i_load_lo || i_load_hi) begin
      if (i_load_lo) mtime_d[31:0]  = i_load_data;
      if (i_load_hi) mtime_d[63:32] = i_load_data;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign o_mtime = mtime_q;

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: bus handshake FSM, register file, coherent
// 64-bit read shadow and registered mtime >= mtimecmp interrupt level.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_interrupt
);

  bus_state_t                state_q, state_d;
  logic                      ready_q, ready_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [31:0]               shadow_q, shadow_d;
  logic [1:0]                ctrl_q, ctrl_d;
  logic [PRESCALE_WIDTH-1:0] reload_q, reload_d;
  logic [63:0]               mtimecmp_q, mtimecmp_d;
  logic                      irq_q, irq_d;

  logic        accept, wr, rd;
  logic [2:0]  reg_idx;
  logic [31:0] reload_ext;
  logic [63:0] mtime;
  logic        unused_addr;

  assign unused_addr = ^{i_address[31:5], i_address[1:0]};

  always_comb begin
    reg_idx = i_address[4:2];
    accept  = (state_q == ST_IDLE) && i_request;
    wr      = accept && i_rw;
    rd      = accept && !i_rw;

    reload_ext                      = '0;
    reload_ext[PRESCALE_WIDTH-1:0]  = reload_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_request) state_d = ST_ACK;
      ST_ACK:  state_d = ST_WAIT;
      ST_WAIT: if (!i_request) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = accept;

    rdata_d  = rdata_q;
    shadow_d = shadow_q;
    if (rd) begin
      case (reg_idx)
        REG_MTIME_LO: begin
          rdata_d  = mtime[31:0];
          shadow_d = mtime[63:32];
        end
        REG_MTIME_HI:    rdata_d = shadow_q;
        REG_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        REG_CONTROL:     rdata_d = {30'd0, ctrl_q};
        REG_PRESCALE:    rdata_d = reload_ext;
        default:         rdata_d = '0;
      endcase
    end

    ctrl_d     = ctrl_q;
    reload_d   = reload_q;
    mtimecmp_d = mtimecmp_q;
    if (wr) begin
      case (reg_idx)
        REG_MTIMECMP_LO: mtimecmp_d[31:0]  = i_wdata;
        REG_MTIMECMP_HI: mtimecmp_d[63:32] = i_wdata;
        REG_CONTROL:     ctrl_d            = i_wdata[1:0];
        REG_PRESCALE:    reload_d          = i_wdata[PRESCALE_WIDTH-1:0];
        default:         ;
      endcase
    end

    irq_d = ctrl_q[CTRL_IRQ_EN] && (mtime >= mtimecmp_q);
  end

  timer_counter #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_counter (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (ctrl_q[CTRL_COUNT_EN]),
    .i_reload     (reload_q),
    .i_reload_load(wr && (reg_idx == REG_PRESCALE)),
    .i_reload_data(i_wdata[PRESCALE_WIDTH-1:0]),
    .i_load_lo    (wr && (reg_idx == REG_MTIME_LO)),
    .i_load_hi    (wr && (reg_idx == REG_MTIME_HI)),
    .i_load_data  (i_wdata),
    .o_mtime      (mtime)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      shadow_q   <= '0;
      ctrl_q     <= '0;
      reload_q   <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      shadow_q   <= shadow_d;
      ctrl_q     <= ctrl_d;
      reload_q   <= reload_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_rdata     = rdata_q;
  assign o_interrupt = irq_q;

endmodule

// File: tb/tb_machine_timer.sv
// Scoreboard bench for machine_timer: bus reads push expected data, a monitor
// pops and compares on every o_ready strobe.
module tb_machine_timer;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_request = 1'b0;
  logic        i_rw = 1'b0;
  logic [31:0] i_address = '0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_interrupt;

  typedef struct {
    bit          is_read;
    logic [2:0]  idx;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  logic      irq_at_ready = 1'b0;

  machine_timer #(.PRESCALE_WIDTH(16)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_request  (i_request),
    .i_rw       (i_rw),
    .i_address  (i_address),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_ready    (o_ready),
    .o_interrupt(o_interrupt)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge i_clock) begin
    if (o_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_ready", 1, 0);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        if (e.is_read) check($sformatf("rdata_r%0d", e.idx), o_rdata, e.exp);
      end
    end
  end

  // Called at a negedge with the bus idle; returns two cycles after the strobe.
  task automatic xfer(input logic rw, input logic [2:0] idx, input logic [31:0] wdata,
                      input logic [31:0] exp, input int hold);
    int pulses = 0;
    int waited = 0;
    bit got = 0;
    sb_q.push_back('{is_read: !rw, idx: idx, exp: exp});
    i_request = 1'b1;
    i_rw      = rw;
    i_address = {27'd0, idx, 2'b00};
    i_wdata   = wdata;
    while (!got && waited < 10) begin
      @(negedge i_clock);
      waited++;
      if (o_ready) begin
        got = 1;
        pulses++;
        irq_at_ready = o_interrupt;
      end
    end
    if (!got) begin
      check("ready_timeout", 0, 1);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
    repeat (hold) begin
      @(negedge i_clock);
      if (o_ready) pulses++;
    end
    i_request = 1'b0;
    repeat (2) begin
      @(negedge i_clock);
      if (o_ready) pulses++;
    end
    check("ready_pulses", pulses, 1);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] data);
    xfer(1'b1, idx, data, 32'd0, 0);
  endtask

  task automatic rd(input logic [2:0] idx, input logic [31:0] exp);
    xfer(1'b0, idx, 32'd0, exp, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clock);
    i_reset = 1'b0;
    check("reset_ready", o_ready, 0);
    check("reset_rdata", o_rdata, 0);
    check("reset_irq", o_interrupt, 0);

    rd(3'd2, 32'hFFFF_FFFF);
    rd(3'd3, 32'hFFFF_FFFF);
    rd(3'd0, 32'd0);
    rd(3'd1, 32'd0);
    rd(3'd4, 32'd0);
    rd(3'd5, 32'd0);
    wr(3'd6, 32'h1234);
    rd(3'd6, 32'd0);
    rd(3'd7, 32'd0);
    check("idle_irq", o_interrupt, 0);

    // Reload 3: one tick per 4 enabled edges; 22 enabled edges -> 5 ticks.
    wr(3'd5, 32'd3);
    rd(3'd5, 32'd3);
    wr(3'd4, 32'd1);
    repeat (19) @(negedge i_clock);
    wr(3'd4, 32'd0);
    rd(3'd0, 32'd5);
    rd(3'd1, 32'd0);
    repeat (10) @(negedge i_clock);
    rd(3'd0, 32'd5);

    // Reload 0, compare at 10: interrupt visible after edge E+11.
    wr(3'd5, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd10);
    rd(3'd2, 32'd10);
    check("irq_disabled", o_interrupt, 0);
    wr(3'd4, 32'd1);
    wr(3'd4, 32'd3);
    for (int k = 6; k <= 14; k++) begin
      @(negedge i_clock);
      check($sformatf("irq_rise_k%0d", k), o_interrupt, (k >= 11) ? 1 : 0);
    end

    wr(3'd3, 32'hFFFF_FFFF);
    check("irq_cmp_write_latency", irq_at_ready, 1);
    check("irq_cmp_write_drop", o_interrupt, 0);
    xfer(1'b0, 3'd2, 32'd0, 32'd10, 5);
    rd(3'd3, 32'hFFFF_FFFF);
    wr(3'd3, 32'd0);
    check("irq_reassert", o_interrupt, 1);
    wr(3'd4, 32'd1);
    check("irq_en_clear_latency", irq_at_ready, 1);
    check("irq_en_clear_drop", o_interrupt, 0);

    // Coherent 64-bit read across the low-word carry, reload 7.
    wr(3'd4, 32'd0);
    wr(3'd5, 32'd7);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'd0);
    wr(3'd4, 32'd1);
    rd(3'd0, 32'hFFFF_FFFF);
    repeat (4) @(negedge i_clock);
    rd(3'd1, 32'd0);
    rd(3'd0, 32'd0);
    rd(3'd1, 32'd1);

    // Bus write to mtime on a tick edge wins; then three ticks before freeze.
    wr(3'd5, 32'd0);
    wr(3'd0, 32'd100);
    wr(3'd4, 32'd0);
    rd(3'd0, 32'd103);
    rd(3'd1, 32'd1);

    // 64-bit wrap with carry into the high word.
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd4, 32'd1);
    wr(3'd4, 32'd0);
    rd(3'd0, 32'd2);
    rd(3'd1, 32'd0);

    // Reset during an access aborts it without a strobe.
    i_request = 1'b1;
    i_rw      = 1'b0;
    i_address = 32'd8;
    i_reset   = 1'b1;
    @(negedge i_clock);
    check("reset_abort_ready", o_ready, 0);
    i_request = 1'b0;
    @(negedge i_clock);
    check("reset_abort_ready2", o_ready, 0);
    i_reset = 1'b0;
    @(negedge i_clock);
    rd(3'd2, 32'hFFFF_FFFF);
    rd(3'd0, 32'd0);
    rd(3'd4, 32'd0);
    check("post_reset_irq", o_interrupt, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
